// File: rtl/uart_fifo_core.sv
// Full-duplex UART with runtime framing (5-8 data bits, parity, 1/2 stop) and TX/RX FIFOs.
// Framing and bit period are captured at the start of each frame; RX entries carry error flags.
module uart_fifo_core #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned TX_DEPTH_LOG2       = 4,
  parameter int unsigned RX_DEPTH_LOG2       = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic [1:0]                     data_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           two_stop_bits_i,
  input  logic [7:0]                     tx_data_i,
  input  logic                           tx_valid_i,
  output logic                           tx_ready_o,
  output logic                           tx_busy_o,
  output logic [TX_DEPTH_LOG2:0]         tx_level_o,
  output logic                           serial_o,
  input  logic                           serial_i,
  output logic [7:0]                     rx_data_o,
  output logic                           rx_parity_err_o,
  output logic                           rx_frame_err_o,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic [RX_DEPTH_LOG2:0]         rx_level_o,
  output logic                           rx_overrun_o,
  input  logic                           overrun_clear_i
);
  localparam int unsigned Cdw = CLOCK_DIVIDER_WIDTH;
  localparam logic [TX_DEPTH_LOG2:0] TxFull = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RxFull = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

  logic [Cdw-1:0] div_eff;
  logic [7:0]     cfg_mask;
  assign div_eff  = (clock_divider_i < Cdw'(4)) ? Cdw'(4) : clock_divider_i;
  assign cfg_mask = 8'hFF >> (~data_bits_i);

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]               tx_mem_q [2**TX_DEPTH_LOG2];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q;
  logic                     tx_push, tx_pop;

  assign tx_ready_o = (tx_cnt_q != TxFull);
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign tx_level_o = tx_cnt_q;

  always_ff @(posedge clock_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e      tx_st_q;
  logic [Cdw-1:0] tx_tmr_q, tx_div_q;
  logic [7:0]     tx_shift_q, tx_load;
  logic [2:0]     tx_bit_q;
  logic           tx_par_en_q, tx_par_q, tx_two_q, tx_stop_more_q, serial_q;
  logic           tx_load_par, tx_line;

  assign tx_load     = tx_mem_q[tx_rd_q] & cfg_mask;
  assign tx_load_par = parity_even_i ? ^tx_load : ~^tx_load;
  // Pop from idle, or at the end of the last stop bit so frames run back to back.
  assign tx_pop = (tx_cnt_q != '0) &&
                  ((tx_st_q == TxIdle) ||
                   (tx_st_q == TxStop && tx_tmr_q == '0 && !tx_stop_more_q));
  assign tx_busy_o = (tx_cnt_q != '0) || (tx_st_q != TxIdle);
  assign serial_o  = serial_q;

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_st_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shift_q[0];
      TxParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_st_q        <= TxIdle;
      tx_tmr_q       <= '0;
      tx_div_q       <= Cdw'(4);
      tx_shift_q     <= '0;
      tx_bit_q       <= '0;
      tx_par_en_q    <= 1'b0;
      tx_par_q       <= 1'b0;
      tx_two_q       <= 1'b0;
      tx_stop_more_q <= 1'b0;
      serial_q       <= 1'b1;
    end else begin
      serial_q <= tx_line;
      if (tx_st_q != TxIdle) begin
        if (tx_tmr_q != '0) begin
          tx_tmr_q <= tx_tmr_q - 1'b1;
        end else begin
          tx_tmr_q <= tx_div_q - 1'b1;
          unique case (tx_st_q)
            TxStart: tx_st_q <= TxData;
            TxData: begin
              tx_shift_q <= tx_shift_q >> 1;
              if (tx_bit_q == '0) begin
                tx_st_q        <= tx_par_en_q ? TxParity : TxStop;
                tx_stop_more_q <= tx_two_q;
              end else begin
                tx_bit_q <= tx_bit_q - 1'b1;
              end
            end
            TxParity: begin
              tx_st_q        <= TxStop;
              tx_stop_more_q <= tx_two_q;
            end
            TxStop: begin
              if (tx_stop_more_q) tx_stop_more_q <= 1'b0;
              else                tx_st_q        <= TxIdle;
            end
            default: tx_st_q <= TxIdle;
          endcase
        end
      end
      if (tx_pop) begin
        tx_st_q     <= TxStart;
        tx_tmr_q    <= div_eff - 1'b1;
        tx_div_q    <= div_eff;
        tx_shift_q  <= tx_load;
        tx_par_q    <= tx_load_par;
        tx_bit_q    <= {1'b1, data_bits_i};
        tx_par_en_q <= parity_bit_i;
        tx_two_q    <= two_stop_bits_i;
      end
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_e      rx_st_q;
  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  logic [Cdw-1:0] rx_tmr_q, rx_div_q;
  logic [7:0]     rx_data_q;
  logic [2:0]     rx_idx_q, rx_last_q;
  logic           rx_par_en_q, rx_even_q, rx_perr_q;
  logic           rx_tick, rx_push;
  logic [9:0]     rx_push_word;

  assign rx_tick      = (rx_tmr_q == '0);
  assign rx_push      = (rx_st_q == RxStop) && rx_tick;
  assign rx_push_word = {~rx_sync_q, rx_perr_q, rx_data_q};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_st_q     <= RxIdle;
      rx_tmr_q    <= '0;
      rx_div_q    <= Cdw'(4);
      rx_data_q   <= '0;
      rx_idx_q    <= '0;
      rx_last_q   <= '0;
      rx_par_en_q <= 1'b0;
      rx_even_q   <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      if (!rx_tick) rx_tmr_q <= rx_tmr_q - 1'b1;
      unique case (rx_st_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_q     <= RxStart;
            rx_tmr_q    <= (div_eff >> 1) - 1'b1;
            rx_div_q    <= div_eff;
            rx_last_q   <= {1'b1, data_bits_i};
            rx_par_en_q <= parity_bit_i;
            rx_even_q   <= parity_even_i;
          end
        end
        RxStart: begin
          if (rx_tick) begin
            if (rx_sync_q) begin
              rx_st_q <= RxIdle;
            end else begin
              rx_st_q   <= RxData;
              rx_tmr_q  <= rx_div_q - 1'b1;
              rx_idx_q  <= '0;
              rx_data_q <= '0;
              rx_perr_q <= 1'b0;
            end
          end
        end
        RxData: begin
          if (rx_tick) begin
            rx_data_q[rx_idx_q] <= rx_sync_q;
            rx_tmr_q            <= rx_div_q - 1'b1;
            if (rx_idx_q == rx_last_q) rx_st_q  <= rx_par_en_q ? RxParity : RxStop;
            else                       rx_idx_q <= rx_idx_q + 1'b1;
          end
        end
        RxParity: begin
          if (rx_tick) begin
            rx_perr_q <= rx_sync_q != (rx_even_q ? ^rx_data_q : ~^rx_data_q);
            rx_tmr_q  <= rx_div_q - 1'b1;
            rx_st_q   <= RxStop;
          end
        end
        // A low stop bit is treated as a possible break: re-arm only once the line is high.
        RxStop:  if (rx_tick) rx_st_q <= rx_sync_q ? RxIdle : RxBreak;
        RxBreak: if (rx_sync_q) rx_st_q <= RxIdle;
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [9:0]               rx_mem_q [2**RX_DEPTH_LOG2];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q;
  logic                     rx_full, rx_pop, rx_wr, rx_drop, rx_ovr_q;
  logic [9:0]               rx_head;

  assign rx_full    = (rx_cnt_q == RxFull);
  assign rx_valid_o = (rx_cnt_q != '0);
  assign rx_pop     = rx_ready_i && rx_valid_o;
  assign rx_wr      = rx_push && (!rx_full || rx_pop);
  assign rx_drop    = rx_push && rx_full && !rx_pop;
  assign rx_head    = rx_mem_q[rx_rd_q];

  assign rx_data_o       = rx_valid_o ? rx_head[7:0] : 8'h00;
  assign rx_parity_err_o = rx_valid_o && rx_head[8];
  assign rx_frame_err_o  = rx_valid_o && rx_head[9];
  assign rx_level_o      = rx_cnt_q;
  assign rx_overrun_o    = rx_ovr_q;

  always_ff @(posedge clock_i) begin
    if (rx_wr) rx_mem_q[rx_wr_q] <= rx_push_word;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (rx_wr)  rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      unique case ({rx_wr, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      if (rx_drop)              rx_ovr_q <= 1'b1;
      else if (overrun_clear_i) rx_ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized bench for uart_fifo_core: TX waveform, loopback, injected RX errors, FIFO limits.
module tb_uart_fifo_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  dbits;
  logic        par_en, par_even, two_stop;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_busy;
  logic [4:0]  tx_level;
  logic        serial_out, serial_in, line_drv, loop_en;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid, rx_ready, rx_ovr, ovr_clr;
  logic [4:0]  rx_level;

  int total = 0;
  int bad = 0;
  bit         frame_bits[$];
  logic [9:0] rx_model[$];
  logic [7:0] fill_bytes[18];
  logic [7:0] b;
  logic       exp_ovr;

  assign serial_in = loop_en ? serial_out : line_drv;

  always #5 clk = ~clk;

  uart_fifo_core dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .clock_divider_i(div),
    .data_bits_i    (dbits),
    .parity_bit_i   (par_en),
    .parity_even_i  (par_even),
    .two_stop_bits_i(two_stop),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .tx_busy_o      (tx_busy),
    .tx_level_o     (tx_level),
    .serial_o       (serial_out),
    .serial_i       (serial_in),
    .rx_data_o      (rx_data),
    .rx_parity_err_o(rx_perr),
    .rx_frame_err_o (rx_ferr),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .rx_level_o     (rx_level),
    .rx_overrun_o   (rx_ovr),
    .overrun_clear_i(ovr_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_d(input int v);
    return (v < 4) ? 4 : v;
  endfunction

  function automatic logic [7:0] mask_of(input logic [1:0] db);
    return 8'((1 << (5 + int'(db))) - 1);
  endfunction

  // Reference frame as a list of line levels, one per bit period.
  task automatic add_frame(input logic [7:0] byte_in);
    logic [7:0] m;
    m = byte_in & mask_of(dbits);
    frame_bits.push_back(1'b0);
    for (int i = 0; i < 5 + int'(dbits); i++) frame_bits.push_back(m[i]);
    if (par_en) frame_bits.push_back(par_even ? ($countones(m) % 2 == 1) : ($countones(m) % 2 == 0));
    frame_bits.push_back(1'b1);
    if (two_stop) frame_bits.push_back(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic check_stream(input int d);
    for (int i = 0; i < frame_bits.size(); i++)
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        check_val("serial_bit", serial_out, frame_bits[i]);
      end
    frame_bits.delete();
  endtask

  task automatic tx_frame(input logic [7:0] v);
    add_frame(v);
    push_byte(v);
    check_val("tx_busy_on", tx_busy, 1);
    @(negedge clk);
    check_val("serial_pre_start", serial_out, 1);
    check_stream(eff_d(int'(div)));
    check_val("tx_busy_off", tx_busy, 0);
  endtask

  task automatic drive_line(input int d);
    for (int i = 0; i < frame_bits.size(); i++) begin
      line_drv = frame_bits[i];
      repeat (d) @(negedge clk);
    end
    line_drv = 1'b1;
    frame_bits.delete();
  endtask

  task automatic rx_check_head(input string tag);
    logic [9:0] e;
    int n;
    e = '0;
    n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, rx_valid, 1);
    if (rx_model.size() > 0) e = rx_model.pop_front();
    check_val({tag, "_data"}, rx_data, e[7:0]);
    check_val({tag, "_perr"}, rx_perr, e[8]);
    check_val({tag, "_ferr"}, rx_ferr, e[9]);
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; div = 16'd8; dbits = 2'b11; par_en = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    tx_data = '0; tx_valid = 1'b0; line_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b0;
    ovr_clr = 1'b0; exp_ovr = 1'b0;
    idle(3);
    check_val("rst_serial", serial_out, 1);
    check_val("rst_tx_ready", tx_ready, 1);
    check_val("rst_tx_busy", tx_busy, 0);
    check_val("rst_tx_level", tx_level, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_level", rx_level, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_rx_errs", {rx_perr, rx_ferr}, 0);
    check_val("rst_overrun", rx_ovr, 0);
    rst = 1'b0;
    idle(2);

    // 8N1 0xA5 at D=8
    tx_frame(8'hA5);

    // 7E2 loopback of 0x3C
    loop_en = 1'b1; dbits = 2'b10; par_en = 1'b1; par_even = 1'b1; two_stop = 1'b1;
    rx_model.push_back({2'b00, 8'h3C});
    tx_frame(8'h3C);
    rx_check_head("lb_3c");

    // Random loopback, including divider values below the minimum
    repeat (8) begin
      div = 16'($urandom_range(12, 0)); dbits = 2'($urandom); par_en = 1'($urandom);
      par_even = 1'($urandom); two_stop = 1'($urandom); b = 8'($urandom);
      rx_model.push_back({2'b00, b & mask_of(dbits)});
      tx_frame(b);
      rx_check_head("lb_rand");
    end
    loop_en = 1'b0;
    idle(4);

    // Injected 8E1 frames: bad parity, low stop with break, then a clean frame
    div = 16'd8; dbits = 2'b11; par_en = 1'b1; par_even = 1'b1; two_stop = 1'b0;
    add_frame(8'h5A);
    frame_bits[9] = !frame_bits[9];
    rx_model.push_back({2'b01, 8'h5A});
    drive_line(8); idle(16);
    add_frame(8'hC3);
    frame_bits[10] = 1'b0;
    repeat (24) frame_bits.push_back(1'b0);
    rx_model.push_back({2'b10, 8'hC3});
    drive_line(8); idle(16);
    add_frame(8'h81);
    rx_model.push_back({2'b00, 8'h81});
    drive_line(8); idle(16);
    check_val("inj_level", rx_level, rx_model.size());
    repeat (3) rx_check_head("inj");

    // RX overrun: 17 frames with nobody popping
    par_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      add_frame(b);
      drive_line(8); idle(16);
      if (rx_model.size() < 16) rx_model.push_back({2'b00, b});
      else exp_ovr = 1'b1;
      check_val("ovr_level", rx_level, rx_model.size());
      check_val("ovr_flag", rx_ovr, exp_ovr);
    end
    ovr_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovr_clr = 1'b0;
    check_val("ovr_cleared", rx_ovr, 0);
    for (int i = 0; i < 16; i++) rx_check_head("ovr_pop");
    check_val("ovr_drained", rx_level, 0);

    // Short glitch must not produce a byte
    div = 16'd16;
    line_drv = 1'b0;
    idle(2);
    line_drv = 1'b1;
    idle(60);
    check_val("glitch_level", rx_level, 0);
    check_val("glitch_valid", rx_valid, 0);

    // TX FIFO fill while the first frame is on the line
    div = 16'd6; dbits = 2'($urandom); par_en = 1'($urandom); par_even = 1'($urandom);
    two_stop = 1'($urandom);
    for (int i = 0; i < 18; i++) fill_bytes[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) add_frame(fill_bytes[i]);
    push_byte(fill_bytes[0]);
    fork
      begin
        @(negedge clk);
        check_stream(6);
      end
      begin
        for (int i = 1; i <= 17; i++) begin
          check_val("fill_ready", tx_ready, (i <= 16));
          tx_data  = fill_bytes[i];
          tx_valid = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check_val("fill_level", tx_level, (i <= 16) ? i : 16);
        end
        tx_valid = 1'b0;
      end
    join
    check_val("fill_busy_off", tx_busy, 0);
    check_val("fill_level_end", tx_level, 0);

    // Reset in the middle of a frame
    div = 16'd8; dbits = 2'b11; par_en = 1'b0;
    push_byte(8'h00);
    idle(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_serial", serial_out, 1);
    check_val("midrst_busy", tx_busy, 0);
    check_val("midrst_level", tx_level, 0);
    idle(10);
    check_val("midrst_serial_hold", serial_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
